// File: rtl/memory_test_sequencer.sv
// Memory exerciser: sweeps addresses 0..DEPTH-1 with write, read-verify or
// write-then-verify passes, counting read mismatches against a seeded pattern.
module memory_test_sequencer #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter int          DEPTH        = 16,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] SEED         = 32'hA5A5_0000,
  parameter int          ERR_WIDTH    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  read_enable,
  output logic [ADDR_WIDTH-1:0] read_address,
  input  logic [DATA_WIDTH-1:0] read_value,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_value,
  output logic [ERR_WIDTH-1:0]  error_count,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] first_error_address
);

  localparam int PW = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] count, count_next;
  logic [3:0]            drain, drain_next;
  logic [1:0]            pass_mode, pass_mode_next;
  logic                  accept;

  logic                  chk_valid;
  logic [DATA_WIDTH-1:0] chk_expected;
  logic [ADDR_WIDTH-1:0] chk_address;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [PW-1:0] s;
    s = PW'(SEED) ^ PW'(a);
    return DATA_WIDTH'(s);
  endfunction

  always_comb begin
    state_next     = state;
    count_next     = count;
    drain_next     = drain;
    pass_mode_next = pass_mode;
    accept         = 1'b0;
    case (state)
      IDLE: begin
        if (start && mode != 2'd3) begin
          accept         = 1'b1;
          pass_mode_next = mode;
          count_next     = '0;
          state_next     = (mode == 2'd0) ? READ : WRITE;
        end
      end
      WRITE: begin
        if (count == LAST) begin
          count_next = '0;
          state_next = (pass_mode == 2'd2) ? READ : DONE;
        end else begin
          count_next = count + 1'b1;
        end
      end
      READ: begin
        if (count == LAST) begin
          drain_next = '0;
          state_next = (READ_LATENCY == 0) ? DONE : DRAIN;
        end else begin
          count_next = count + 1'b1;
        end
      end
      DRAIN: begin
        if (drain == 4'(READ_LATENCY - 1)) state_next = DONE;
        else                               drain_next = drain + 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign read_enable  = (state == READ);
  assign write_enable = (state == WRITE);
  assign error        = |error_count;

  // Address/data outputs are registered from the next counter value so they
  // track the counter while active and hold their last value otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      drain         <= '0;
      pass_mode     <= 2'd0;
      read_address  <= '0;
      write_address <= '0;
      write_value   <= '0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      drain     <= drain_next;
      pass_mode <= pass_mode_next;
      if (state_next == WRITE) begin
        write_address <= count_next;
        write_value   <= pattern(count_next);
      end
      if (state_next == READ) read_address <= count_next;
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_comb
      assign chk_valid    = read_enable;
      assign chk_expected = pattern(read_address);
      assign chk_address  = read_address;
    end else begin : g_pipe
      logic                  valid_pipe [READ_LATENCY];
      logic [DATA_WIDTH-1:0] exp_pipe   [READ_LATENCY];
      logic [ADDR_WIDTH-1:0] addr_pipe  [READ_LATENCY];

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < READ_LATENCY; i++) begin
            valid_pipe[i] <= 1'b0;
            exp_pipe[i]   <= '0;
            addr_pipe[i]  <= '0;
          end
        end else begin
          valid_pipe[0] <= read_enable;
          exp_pipe[0]   <= pattern(read_address);
          addr_pipe[0]  <= read_address;
          for (int i = 1; i < READ_LATENCY; i++) begin
            valid_pipe[i] <= valid_pipe[i-1];
            exp_pipe[i]   <= exp_pipe[i-1];
            addr_pipe[i]  <= addr_pipe[i-1];
          end
        end
      end

      assign chk_valid    = valid_pipe[READ_LATENCY-1];
      assign chk_expected = exp_pipe[READ_LATENCY-1];
      assign chk_address  = addr_pipe[READ_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error_count         <= '0;
      first_error_address <= '0;
    end else if (accept) begin
      error_count         <= '0;
      first_error_address <= '0;
    end else if (chk_valid && read_value != chk_expected) begin
      if (error_count != '1) error_count <= error_count + 1'b1;
      if (error_count == '0) first_error_address <= chk_address;
    end
  end

endmodule

// File: tb/tb_memory_test_sequencer.sv
// Bench for memory_test_sequencer: three instances (default config, RL=3 with a
// 2-bit error counter, DEPTH=1 with RL=0) against simple memory models.
module tb_memory_test_sequencer;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;
  always @(posedge clock) edges <= edges + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [2:0] start_v;
  logic [1:0] mode_v [3];

  // Instance A: defaults (DEPTH 16, RL 1, ERR_WIDTH 16)
  logic        busy_a, done_a, re_a, we_a, err_a;
  logic [31:0] ra_a, wa_a, wv_a, rv_a, fea_a;
  logic [15:0] ec_a;
  // Instance B: RL 3, ERR_WIDTH 2, read-only use
  logic        busy_b, done_b, re_b, we_b, err_b;
  logic [31:0] ra_b, wa_b, wv_b, rv_b, fea_b;
  logic [1:0]  ec_b;
  // Instance C: DEPTH 1, RL 0, narrow buses
  logic        busy_c, done_c, re_c, we_c, err_c;
  logic [3:0]  ra_c, wa_c, fea_c;
  logic [7:0]  wv_c, rv_c;
  logic [15:0] ec_c;

  memory_test_sequencer dut_a (
    .clock(clock), .reset(reset), .start(start_v[0]), .mode(mode_v[0]),
    .busy(busy_a), .done(done_a), .read_enable(re_a), .read_address(ra_a),
    .read_value(rv_a), .write_enable(we_a), .write_address(wa_a), .write_value(wv_a),
    .error_count(ec_a), .error(err_a), .first_error_address(fea_a));

  memory_test_sequencer #(.READ_LATENCY(3), .ERR_WIDTH(2)) dut_b (
    .clock(clock), .reset(reset), .start(start_v[1]), .mode(mode_v[1]),
    .busy(busy_b), .done(done_b), .read_enable(re_b), .read_address(ra_b),
    .read_value(rv_b), .write_enable(we_b), .write_address(wa_b), .write_value(wv_b),
    .error_count(ec_b), .error(err_b), .first_error_address(fea_b));

  memory_test_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DEPTH(1), .READ_LATENCY(0),
                          .SEED(32'h0000_005A)) dut_c (
    .clock(clock), .reset(reset), .start(start_v[2]), .mode(mode_v[2]),
    .busy(busy_c), .done(done_c), .read_enable(re_c), .read_address(ra_c),
    .read_value(rv_c), .write_enable(we_c), .write_address(wa_c), .write_value(wv_c),
    .error_count(ec_c), .error(err_c), .first_error_address(fea_c));

  logic [2:0]  busy_v, done_v, we_v, re_v, err_v;
  logic [15:0] ec_v  [3];
  logic [31:0] fea_v [3];
  assign busy_v = {busy_c, busy_b, busy_a};
  assign done_v = {done_c, done_b, done_a};
  assign we_v   = {we_c, we_b, we_a};
  assign re_v   = {re_c, re_b, re_a};
  assign err_v  = {err_c, err_b, err_a};
  assign ec_v[0] = ec_a;
  assign ec_v[1] = {14'b0, ec_b};
  assign ec_v[2] = ec_c;
  assign fea_v[0] = fea_a;
  assign fea_v[1] = fea_b;
  assign fea_v[2] = {28'b0, fea_c};

  // Memory A: one-cycle read, optional bit0 corruption per address
  logic [31:0] mem_a [16];
  logic [15:0] corrupt_a = 16'h0;
  always @(posedge clock) begin
    if (we_a) mem_a[wa_a[3:0]] <= wv_a;
    if (re_a) rv_a <= mem_a[ra_a[3:0]] ^ {31'b0, corrupt_a[ra_a[3:0]]};
  end

  // Memory B: preloaded, read latency selectable (1..4)
  logic [31:0] mem_b [16];
  logic [31:0] pa_b  [4];
  logic        pe_b  [4];
  int          lat_b = 3;
  always @(posedge clock) begin
    pa_b[0] <= ra_b;
    pe_b[0] <= re_b;
    for (int i = 1; i < 4; i++) begin
      pa_b[i] <= pa_b[i-1];
      pe_b[i] <= pe_b[i-1];
    end
  end
  assign rv_b = pe_b[lat_b-1] ? mem_b[pa_b[lat_b-1][3:0]] : 32'h0;

  // Memory C: single word, combinational read
  logic [7:0] mem_c     = 8'h00;
  logic [7:0] corrupt_c = 8'h00;
  always @(posedge clock) if (we_c) mem_c <= wv_c;
  assign rv_c = mem_c ^ corrupt_c;

  typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} req_t;
  typedef struct packed {int inst; int cycles; int errs; logic [31:0] first;} res_t;
  req_t exp_q [$];
  res_t res_q [$];

  int start_edge [3];
  int busy_cnt   [3];
  int done_cnt   [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_edge[k] = 0;
      busy_cnt[k]   = 0;
      done_cnt[k]   = 0;
    end
  end

  always @(negedge clock) begin
    req_t r;
    res_t s;
    for (int k = 0; k < 3; k++) begin
      if (we_v[k] | re_v[k]) check("rw_exclusive", we_v[k] & re_v[k], 1'b0);
      if (busy_v[k]) busy_cnt[k]++;
      if (done_v[k]) begin
        done_cnt[k]++;
        check("result_pending", res_q.size() > 0, 1'b1);
        if (res_q.size() > 0) begin
          s = res_q.pop_front();
          check("done_instance", k, s.inst);
          check("done_cycle", edges - start_edge[k], s.cycles);
          check("busy_cycles", busy_cnt[k], s.cycles);
          check("error_count", ec_v[k], s.errs);
          check("error_flag", err_v[k], s.errs != 0);
          check("first_error_address", fea_v[k], s.first);
          if (k == 0) check("requests_drained", exp_q.size(), 0);
          $display("pass inst=%0d cycles=%0d errors=%0d first=0x%0h",
                   k, edges - start_edge[k], ec_v[k], fea_v[k]);
        end
      end
    end
    if (we_a || re_a) begin
      check("request_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        check("req_kind", we_a, r.wr);
        check("req_addr", we_a ? wa_a : ra_a, r.addr);
        if (we_a) check("write_value", wv_a, r.data);
      end
    end
    if (we_c) begin
      check("c_write_addr", wa_c, 4'h0);
      check("c_write_value", wv_c, 8'h5A);
    end
    if (re_c) check("c_read_addr", ra_c, 4'h0);
  end

  task automatic push_reqs(input logic [1:0] m);
    for (int a = 0; a < 16; a++)
      if (m != 2'd0) exp_q.push_back('{1'b1, 32'(a), 32'hA5A5_0000 ^ 32'(a)});
    for (int a = 0; a < 16; a++)
      if (m != 2'd1) exp_q.push_back('{1'b0, 32'(a), 32'h0});
  endtask

  task automatic run(input int k, input logic [1:0] m, input bit hold,
                     input int cycles, input int errs, input logic [31:0] first);
    int d0;
    bit seen;
    res_q.push_back('{k, cycles, errs, first});
    if (k == 0) push_reqs(m);
    @(negedge clock);
    d0            = done_cnt[k];
    mode_v[k]     = m;
    start_v[k]    = 1'b1;
    start_edge[k] = edges;
    busy_cnt[k]   = 0;
    if (!hold) begin
      @(negedge clock);
      start_v[k] = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clock);
      if (done_cnt[k] != d0) seen = 1'b1;
    end
    start_v[k] = 1'b0;
    check("done_seen", seen, 1'b1);
    @(negedge clock);
    check("idle_after_done", busy_v[k], 1'b0);
    @(negedge clock);
    check("hold_error_count", ec_v[k], errs);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int d0;
    reset   = 1'b1;
    start_v = 3'b000;
    for (int k = 0; k < 3; k++) mode_v[k] = 2'd0;
    for (int i = 0; i < 4; i++) pe_b[i] = 1'b0;
    for (int a = 0; a < 16; a++) mem_b[a] = 32'hA5A5_0000 ^ 32'(a);
    repeat (3) @(negedge clock);
    check("reset_busy", busy_v, 3'b000);
    check("reset_done", done_v, 3'b000);
    check("reset_read_address", ra_a, 32'h0);
    check("reset_write_value", wv_a, 32'h0);
    check("reset_error_count", ec_a, 16'h0);
    reset = 1'b0;

    // A: clean write-then-verify, then with corrupted reads at 5 and 9
    run(0, 2'd2, 1'b0, 34, 0, 32'd0);
    corrupt_a = 16'h0220;
    run(0, 2'd2, 1'b0, 34, 2, 32'd5);
    run(0, 2'd1, 1'b0, 17, 0, 32'd0);
    corrupt_a = 16'h0000;
    // start held high through the whole pass must not restart it
    run(0, 2'd0, 1'b1, 18, 0, 32'd0);

    // A: mode 3 start is ignored
    @(negedge clock);
    d0 = done_cnt[0];
    mode_v[0] = 2'd3;
    start_v[0] = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("mode3_busy", busy_a, 1'b0);
    end
    start_v[0] = 1'b0;
    check("mode3_no_done", done_cnt[0], d0);

    // A: reset during the 7th write
    push_reqs(2'd2);
    @(negedge clock);
    mode_v[0] = 2'd2;
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (we_a && wa_a == 32'd6) found = 1'b1;
      else @(negedge clock);
    end
    check("reached_write7", found, 1'b1);
    d0 = done_cnt[0];
    reset = 1'b1;
    #1;
    check("mid_reset_busy", busy_a, 1'b0);
    check("mid_reset_we", we_a, 1'b0);
    check("mid_reset_write_address", wa_a, 32'h0);
    check("mid_reset_write_value", wv_a, 32'h0);
    check("mid_reset_error_count", ec_a, 16'h0);
    repeat (3) @(negedge clock);
    check("mid_reset_no_done", done_cnt[0], d0);
    reset = 1'b0;
    exp_q.delete();
    run(0, 2'd2, 1'b0, 34, 0, 32'd0);

    // B: correct latency, then data arriving one cycle early fails all reads
    lat_b = 3;
    run(1, 2'd0, 1'b0, 20, 0, 32'd0);
    lat_b = 2;
    run(1, 2'd0, 1'b0, 20, 3, 32'd0);

    // C: DEPTH=1, combinational compare
    run(2, 2'd2, 1'b0, 3, 0, 32'd0);
    corrupt_c = 8'h01;
    run(2, 2'd0, 1'b0, 2, 1, 32'd0);
    run(2, 2'd1, 1'b0, 2, 0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
